// File: rtl/crc_frame_checker.sv
// Receive-side CRC checker: accumulates the CRC remainder over a beat stream and
// reports pass/fail plus saturating frame/error counts when the last beat arrives.
module crc_frame_checker #(
    parameter int              DW = 64,
    parameter int              CW = 16,
    parameter logic [CW:0]     CP = 17'h18005
) (
    input  logic               Clk_i,
    input  logic               Rst_n_i,
    input  logic [DW-1:0]      Dat_i,
    input  logic               Dat_Vld_i,
    input  logic               Dat_Last_i,
    input  logic [CW-1:0]      Crc_i,
    output logic               Dat_Rdy_o,
    output logic               Res_Vld_o,
    output logic               Res_Ok_o,
    output logic [CW-1:0]      Crc_Calc_o,
    input  logic               Res_Rdy_i,
    output logic [15:0]        Frm_Cnt_o,
    output logic [15:0]        Err_Cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [CW-1:0] POLY = CP[CW-1:0];

    state_t          state_q;
    logic [CW-1:0]   rem_q;
    logic [CW-1:0]   rem_d;
    logic [CW-1:0]   crc_calc_q;
    logic            res_vld_q;
    logic            res_ok_q;
    logic [15:0]     frm_cnt_q;
    logic [15:0]     err_cnt_q;
    logic            beat_acc;
    logic            fb;

    assign beat_acc = Dat_Vld_i && !res_vld_q;

    // Serial MSB-first division unrolled over the beat; equals
    // rem({R, DW'b0} ^ {Dat_i, CW'b0}) mod CP.
    always_comb begin
        rem_d = rem_q;
        fb    = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            fb    = rem_d[CW-1] ^ Dat_i[i];
            rem_d = {rem_d[CW-2:0], 1'b0} ^ (fb ? POLY : {CW{1'b0}});
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            crc_calc_q <= '0;
            res_vld_q  <= 1'b0;
            res_ok_q   <= 1'b0;
            frm_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (beat_acc) begin
                        if (Dat_Last_i) begin
                            state_q    <= RESULT;
                            rem_q      <= rem_d;
                            crc_calc_q <= rem_d;
                            res_vld_q  <= 1'b1;
                            res_ok_q   <= (rem_d == Crc_i);
                            if (frm_cnt_q != 16'hFFFF) begin
                                frm_cnt_q <= frm_cnt_q + 16'd1;
                            end
                            if ((rem_d != Crc_i) && (err_cnt_q != 16'hFFFF)) begin
                                err_cnt_q <= err_cnt_q + 16'd1;
                            end
                        end else begin
                            state_q <= ACC;
                            rem_q   <= rem_d;
                        end
                    end
                end
                RESULT: begin
                    if (Res_Rdy_i) begin
                        state_q   <= IDLE;
                        rem_q     <= '0;
                        res_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rem_q     <= '0;
                    res_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign Dat_Rdy_o  = !res_vld_q;
    assign Res_Vld_o  = res_vld_q;
    assign Res_Ok_o   = res_ok_q;
    assign Crc_Calc_o = crc_calc_q;
    assign Frm_Cnt_o  = frm_cnt_q;
    assign Err_Cnt_o  = err_cnt_q;

endmodule
